// File: rtl/tl_countdown_display.sv
// tl_countdown_display
// Drives a 4-digit multiplexed common-anode 7-segment display from the
// traffic-light controller's two countdowns and six lamp drives.
// Frame order: T1 tens, T1 ones, T2 tens, T2 ones. The countdown values are
// snapshotted once per frame, so a frame never mixes old and new values.
// Leading tens zeros are blanked. The digits of a road in its yellow phase
// blink. A sticky fault flag is raised when the lamp combination is illegal.
// While the fault flag is set, every digit shows a dash.
// Handshake: there is none. Inputs are sampled on every rising CLK edge, and
// AN/SEG/ERR are registered outputs that are valid on every cycle.
module tl_countdown_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       CLK,
    input  logic       RET,
    input  logic [4:0] T1,
    input  logic [4:0] T2,
    input  logic       MG,
    input  logic       MY,
    input  logic       MR,
    input  logic       CG,
    input  logic       CY,
    input  logic       CR,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       ERR
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Registered inputs
    logic [4:0] in_t1, in_t2;
    logic       in_mg, in_my, in_mr, in_cg, in_cy, in_cr;
    logic       check_en;

    // Scan state
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;

    // Per-frame snapshot
    logic [4:0] snap_t1, snap_t2;
    logic       snap_my, snap_cy;

    // Blink phase (1 = digits shown)
    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    logic          err_q;
    logic          fault;

    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic [4:0] cur_t;
    logic       cur_off;
    logic [1:0] cur_tens;
    logic [3:0] cur_ones;

    function automatic logic [1:0] tens_of(input logic [4:0] t);
        logic [1:0] r;
        if (t >= 5'd30)      r = 2'd3;
        else if (t >= 5'd20) r = 2'd2;
        else if (t >= 5'd10) r = 2'd1;
        else                 r = 2'd0;
        return r;
    endfunction

    function automatic logic [3:0] ones_of(input logic [4:0] t);
        logic [4:0] r;
        if (t >= 5'd30)      r = t - 5'd30;
        else if (t >= 5'd20) r = t - 5'd20;
        else if (t >= 5'd10) r = t - 5'd10;
        else                 r = t;
        return 4'(r);
    endfunction

    // Segment codes {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Input stage: register every input each cycle. Checking is enabled one
    // cycle after reset, so the all-zero reset lamps never count as a fault.
    always_ff @(posedge CLK or negedge RET) begin
        if (!RET) begin
            in_t1    <= '0;
            in_t2    <= '0;
            in_mg    <= 1'b0;
            in_my    <= 1'b0;
            in_mr    <= 1'b0;
            in_cg    <= 1'b0;
            in_cy    <= 1'b0;
            in_cr    <= 1'b0;
            check_en <= 1'b0;
        end else begin
            in_t1    <= T1;
            in_t2    <= T2;
            in_mg    <= MG;
            in_my    <= MY;
            in_mr    <= MR;
            in_cg    <= CG;
            in_cy    <= CY;
            in_cr    <= CR;
            check_en <= 1'b1;
        end
    end

    // Digit scan: the prescaler and the digit index. The snapshot is taken
    // as idx wraps 3->0, which is the start of a new frame.
    always_ff @(posedge CLK or negedge RET) begin
        if (!RET) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            snap_t1  <= '0;
            snap_t2  <= '0;
            snap_my  <= 1'b0;
            snap_cy  <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
            if (idx == 2'd3) begin
                snap_t1 <= in_t1;
                snap_t2 <= in_t2;
                snap_my <= in_my;
                snap_cy <= in_cy;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Free-running blink phase. It toggles every BLINK_DIV cycles and
    // starts in the ON phase.
    always_ff @(posedge CLK or negedge RET) begin
        if (!RET) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Lamp-legality check on the registered lamps
    always_comb begin
        fault = 1'b0;
        if ((2'(in_mg) + 2'(in_my) + 2'(in_mr)) != 2'd1) fault = 1'b1;
        if ((2'(in_cg) + 2'(in_cy) + 2'(in_cr)) != 2'd1) fault = 1'b1;
        if (!in_mr && !in_cr)                            fault = 1'b1;
    end

    // Sticky fault flag. Only reset clears it.
    always_ff @(posedge CLK or negedge RET) begin
        if (!RET)                  err_q <= 1'b0;
        else if (check_en && fault) err_q <= 1'b1;
    end

    // Digit selection. Blanking and blinking are applied here, and the
    // fault dash takes priority over both.
    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        cur_t    = idx[1] ? snap_t2 : snap_t1;
        cur_off  = ~blink_on & (idx[1] ? snap_cy : snap_my);
        cur_tens = tens_of(cur_t);
        cur_ones = ones_of(cur_t);
        case (idx)
            2'd0:    an_next = 4'b0111;
            2'd1:    an_next = 4'b1011;
            2'd2:    an_next = 4'b1101;
            default: an_next = 4'b1110;
        endcase
        if (err_q) begin
            seg_next = SEG_DASH;
        end else if (cur_off) begin
            seg_next = SEG_BLANK;
        end else if (!idx[0]) begin
            seg_next = (cur_tens == 2'd0) ? SEG_BLANK : seg_code({2'b00, cur_tens});
        end else begin
            seg_next = seg_code(cur_ones);
        end
    end

    // Registered display outputs. Reset blanks them asynchronously.
    always_ff @(posedge CLK or negedge RET) begin
        if (!RET) begin
            AN  <= 4'b1111;
            SEG <= SEG_BLANK;
        end else begin
            AN  <= an_next;
            SEG <= seg_next;
        end
    end

    assign ERR = err_q;

endmodule
